// File: rtl/spi_fetch_pkg.sv
// -----------------------------------------------------------------------------
// spi_fetch_pkg
// Shared definitions for the SPI flash word-fetch engine.
//   state_t      : fetch FSM states (IDLE -> SELECT -> SHIFT -> DONE)
//   CMD_*        : flash opcodes (READ 0x03, FAST READ 0x0B)
//   *_BITS       : frame field widths on the single SPI lane
//   le_word()    : reorders a byte-serial (first byte in MSBs) word so the
//                  first received byte lands in [7:0]
// -----------------------------------------------------------------------------
package spi_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    SHIFT  = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [7:0]  CMD_READ      = 8'h03;
  localparam logic [7:0]  CMD_FAST_READ = 8'h0B;

  localparam int unsigned CMD_BITS   = 8;
  localparam int unsigned ADDR_BITS  = 24;
  localparam int unsigned DATA_BITS  = 32;
  localparam int unsigned DUMMY_BITS = 8;

  // rx register holds byte0 in [31:24] after shifting; return it little-endian.
  function automatic logic [31:0] le_word(input logic [31:0] msb_first);
    return {msb_first[7:0], msb_first[15:8], msb_first[23:16], msb_first[31:24]};
  endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// -----------------------------------------------------------------------------
// spi_sck_gen
// SPI mode-0 clock generator. While en_i is high, sck_o toggles every CLK_DIV
// system clocks. rise_o / fall_o are single-cycle strobes asserted in the
// cycle whose closing clock edge makes sck_o go high / low, so a consumer
// acting on a strobe acts on the same edge the pad clock changes.
// When en_i is low the divider is cleared and sck_o parks low.
// Ports:
//   clock, reset : system clock, asynchronous active-high reset
//   en_i         : run the divider
//   sck_o        : registered SPI clock (to flash_clk)
//   rise_o/fall_o: edge strobes
// -----------------------------------------------------------------------------
module spi_sck_gen #(
  parameter int unsigned CLK_DIV = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic en_i,
  output logic sck_o,
  output logic rise_o,
  output logic fall_o
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic [7:0] div_q;
  logic       sck_q;
  logic       tick_s;

  // Strobe on the last divider count of each half-period.
  always_comb begin
    tick_s = en_i && (div_q == DIV_LAST);
    rise_o = tick_s && !sck_q;
    fall_o = tick_s && sck_q;
  end

  // Divider counter and SCK toggle register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_q <= 8'd0;
      sck_q <= 1'b0;
    end else if (!en_i) begin
      div_q <= 8'd0;
      sck_q <= 1'b0;
    end else if (tick_s) begin
      div_q <= 8'd0;
      sck_q <= !sck_q;
    end else begin
      div_q <= div_q + 8'd1;
    end
  end

  assign sck_o = sck_q;

endmodule

// File: rtl/spi_flash_fetch.sv
// -----------------------------------------------------------------------------
// spi_flash_fetch
// Word-fetch engine: accepts a 24-bit byte address, issues a single-lane SPI
// read to the boot flash and returns one little-endian 32-bit word.
// Optional build macro: SPI_FETCH_FAST_READ_EN
//   defined   -> opcode 0x0B + 8 dummy SCK cycles, 72-bit frame (READ_CMD unused)
//   undefined -> opcode READ_CMD, 64-bit frame
// Ports:
//   clock, reset      : system clock, asynchronous active-high reset
//   req_valid/req_addr: fetch request, address sampled on acceptance
//   req_ready         : high only while idle
//   rdata/rdata_valid : fetched word and its one-cycle strobe (rdata held)
//   flash_csb/clk/io0 : SPI chip select (low active), SCK (mode 0), MOSI
//   flash_io1         : MISO, sampled synchronously on SCK rising strobes
// Timing: accept edge -> SELECT (1 clk) -> SHIFT (2*NBITS*CLK_DIV clks)
//   -> DONE (1 clk) whose closing edge raises rdata_valid and flash_csb,
//   giving 2*NBITS*CLK_DIV+2 clocks from acceptance to rdata_valid.
// -----------------------------------------------------------------------------
module spi_flash_fetch
  import spi_fetch_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 1,
  parameter logic [7:0]  READ_CMD = CMD_READ
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [23:0] req_addr,
  output logic        req_ready,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        flash_csb,
  output logic        flash_clk,
  output logic        flash_io0,
  input  logic        flash_io1
);

`ifdef SPI_FETCH_FAST_READ_EN
  localparam logic [7:0]  CMD   = CMD_FAST_READ;
  localparam int unsigned NBITS = CMD_BITS + ADDR_BITS + DUMMY_BITS + DATA_BITS;
`else
  localparam logic [7:0]  CMD   = READ_CMD;
  localparam int unsigned NBITS = CMD_BITS + ADDR_BITS + DATA_BITS;
`endif

  localparam int unsigned TX_W     = CMD_BITS + ADDR_BITS;
  localparam logic [6:0]  LAST_BIT = 7'(NBITS - 1);

  state_t            state_q;
  logic [TX_W-1:0]   tx_q;
  logic [TX_W-1:0]   tx_shift_d;
  logic [31:0]       rx_q;
  logic [31:0]       rx_shift_d;
  logic [6:0]        bit_cnt_q;
  logic              csb_q;
  logic              io0_q;
  logic              ready_q;
  logic [31:0]       rdata_q;
  logic              rvalid_q;
  logic              sck_en_s;
  logic              sck_rise_s;
  logic              sck_fall_s;

  // Next values of the shift registers; tx shifts in zeros so io0 falls to 0
  // once command and address have gone out (covers dummy and data phases).
  always_comb begin
    sck_en_s   = (state_q == SHIFT);
    tx_shift_d = {tx_q[TX_W-2:0], 1'b0};
    rx_shift_d = {rx_q[30:0], flash_io1};
  end

  spi_sck_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sck_gen (
    .clock  (clock),
    .reset  (reset),
    .en_i   (sck_en_s),
    .sck_o  (flash_clk),
    .rise_o (sck_rise_s),
    .fall_o (sck_fall_s)
  );

  // Fetch FSM with registered pad and response outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      tx_q      <= '0;
      rx_q      <= 32'd0;
      bit_cnt_q <= 7'd0;
      csb_q     <= 1'b1;
      io0_q     <= 1'b0;
      ready_q   <= 1'b1;
      rdata_q   <= 32'd0;
      rvalid_q  <= 1'b0;
    end else begin
      rvalid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid && ready_q) begin
            tx_q      <= {CMD, req_addr};
            io0_q     <= CMD[7];
            csb_q     <= 1'b0;
            ready_q   <= 1'b0;
            bit_cnt_q <= 7'd0;
            state_q   <= SELECT;
          end
        end
        SELECT: begin
          state_q <= SHIFT;
        end
        SHIFT: begin
          // Every rising edge is captured; only the final 32 survive in rx_q.
          if (sck_rise_s) begin
            rx_q <= rx_shift_d;
          end
          if (sck_fall_s) begin
            tx_q      <= tx_shift_d;
            io0_q     <= tx_shift_d[TX_W-1];
            bit_cnt_q <= bit_cnt_q + 7'd1;
            if (bit_cnt_q == LAST_BIT) begin
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          csb_q    <= 1'b1;
          io0_q    <= 1'b0;
          rdata_q  <= le_word(rx_q);
          rvalid_q <= 1'b1;
          ready_q  <= 1'b1;
          state_q  <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign req_ready   = ready_q;
  assign rdata       = rdata_q;
  assign rdata_valid = rvalid_q;
  assign flash_csb   = csb_q;
  assign flash_io0   = io0_q;

endmodule

// File: tb/tb_spi_flash_fetch.sv
// -----------------------------------------------------------------------------
// tb_spi_flash_fetch
// Directed bench for spi_flash_fetch. Two instances (CLK_DIV=1 and CLK_DIV=3)
// share one behavioural flash model through a select mux; the idle instance
// keeps its chip select high. Honours SPI_FETCH_FAST_READ_EN for expectations.
// -----------------------------------------------------------------------------
module tb_spi_flash_fetch;

`ifdef SPI_FETCH_FAST_READ_EN
  localparam int         NB      = 72;
  localparam logic [7:0] EXP_CMD = 8'h0B;
`else
  localparam int         NB      = 64;
  localparam logic [7:0] EXP_CMD = 8'h03;
`endif
  localparam int HDR  = NB - 32;        // bits before the first data bit
  localparam int LAT1 = 2 * NB + 2;     // 130 (146 with fast read)
  localparam int LAT3 = 2 * NB * 3 + 2; // 386 (434 with fast read)

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [23:0] req_addr;
  logic        sel;
  logic        flash_io1;

  logic        req_valid_1, req_ready_1, rdata_valid_1, flash_csb_1, flash_clk_1, flash_io0_1;
  logic        req_valid_3, req_ready_3, rdata_valid_3, flash_csb_3, flash_clk_3, flash_io0_3;
  logic [31:0] rdata_1, rdata_3;

  wire         m_ready  = sel ? req_ready_3   : req_ready_1;
  wire  [31:0] m_rdata  = sel ? rdata_3       : rdata_1;
  wire         m_rvalid = sel ? rdata_valid_3 : rdata_valid_1;
  wire         m_csb    = sel ? flash_csb_3   : flash_csb_1;
  wire         m_clk    = sel ? flash_clk_3   : flash_clk_1;
  wire         m_io0    = sel ? flash_io0_3   : flash_io0_1;

  assign req_valid_1 = req_valid & ~sel;
  assign req_valid_3 = req_valid & sel;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  spi_flash_fetch #(.CLK_DIV(1)) u_dut1 (
    .clock(clock), .reset(reset), .req_valid(req_valid_1), .req_addr(req_addr),
    .req_ready(req_ready_1), .rdata(rdata_1), .rdata_valid(rdata_valid_1),
    .flash_csb(flash_csb_1), .flash_clk(flash_clk_1), .flash_io0(flash_io0_1),
    .flash_io1(flash_io1)
  );

  spi_flash_fetch #(.CLK_DIV(3)) u_dut3 (
    .clock(clock), .reset(reset), .req_valid(req_valid_3), .req_addr(req_addr),
    .req_ready(req_ready_3), .rdata(rdata_3), .rdata_valid(rdata_valid_3),
    .flash_csb(flash_csb_3), .flash_clk(flash_clk_3), .flash_io0(flash_io0_3),
    .flash_io1(flash_io1)
  );

  // ---------------- behavioural flash (mode 0) ----------------
  logic [7:0]  mem [0:8191];
  logic [31:0] cap;          // {cmd, addr} as seen on io0
  int          rise_cnt;
  int          fall_cnt;
  int          io0_nz;       // io0 high on any rise after the address
  logic        prev_clk = 1'b0;
  logic        prev_csb = 1'b1;

  always @(m_clk or m_csb) begin : flash_model
    automatic int          f;
    automatic int          d;
    automatic logic [7:0]  b;
    automatic logic [23:0] idx;
    if (!m_csb && prev_csb) begin
      rise_cnt  <= 0;
      fall_cnt  <= 0;
      io0_nz    <= 0;
      cap       <= 32'd0;
      flash_io1 <= 1'b0;
    end else if (!m_csb && m_clk && !prev_clk) begin
      if (rise_cnt < 32) cap <= {cap[30:0], m_io0};
      else if (m_io0) io0_nz <= io0_nz + 1;
      rise_cnt <= rise_cnt + 1;
    end else if (!m_csb && !m_clk && prev_clk) begin
      f = fall_cnt + 1;
      fall_cnt <= f;
      d = f - HDR;
      if (d >= 0 && d < 32) begin
        idx = (cap[23:0] + 24'(d / 8)) & 24'h001FFF;
        b = mem[idx[12:0]];
        flash_io1 <= b[3'(7 - (d % 8))];
      end else begin
        flash_io1 <= 1'b0;
      end
    end
    prev_clk <= m_clk;
    prev_csb <= m_csb;
  end

  // ---------------- chip-select monitor ----------------
  int   csb_low_cnt = 0;
  int   high_run    = 100;
  int   last_gap    = 100;
  logic mon_prev    = 1'b1;

  always @(posedge clock) begin
    if (!m_csb) begin
      csb_low_cnt <= csb_low_cnt + 1;
      if (mon_prev) last_gap <= high_run;
      high_run <= 0;
    end else begin
      high_run <= high_run + 1;
    end
    mon_prev <= m_csb;
  end

  // ---------------- stimulus helper (observations only) ----------------
  task automatic fetch(input logic [23:0] a, input bit hold, input bit chain,
                       input logic [23:0] next_a, output logic [31:0] data,
                       output int lat, output int busy_bad, output int pulse_bad);
    req_addr  = a;
    req_valid = 1'b1;
    data      = 32'd0;
    lat       = -1;
    busy_bad  = 0;
    pulse_bad = 0;
    for (int w = 0; w < 2000 && m_ready !== 1'b1; w++) @(negedge clock);
    @(posedge clock);              // accepting edge
    @(negedge clock);
    if (!hold) req_valid = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (n > 0) @(negedge clock);
      if (m_rvalid === 1'b1) begin
        lat  = n;
        data = m_rdata;
        break;
      end
      if (m_ready !== 1'b0) busy_bad++;
      if (hold) req_addr = a ^ 24'(n + 1);
    end
    if (chain) begin
      req_addr  = next_a;
      req_valid = 1'b1;
    end else begin
      req_valid = 1'b0;
      @(negedge clock);
      if (m_rvalid !== 1'b0) pulse_bad = 1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    sel = 1'b0;
    @(negedge clock);
    checks++; if (m_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", m_ready); end
    checks++; if (m_csb !== 1'b1) begin errors++; $display("FAIL reset_csb: got %b expected 1", m_csb); end
    checks++; if (m_clk !== 1'b0) begin errors++; $display("FAIL reset_clk: got %b expected 0", m_clk); end
    checks++; if (m_io0 !== 1'b0) begin errors++; $display("FAIL reset_io0: got %b expected 0", m_io0); end
    checks++; if (m_rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", m_rdata); end
    checks++; if (m_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b expected 0", m_rvalid); end
    checks++; if (flash_csb_3 !== 1'b1) begin errors++; $display("FAIL reset_csb_div3: got %b expected 1", flash_csb_3); end
  endtask

  task automatic test_read_div1;
    logic [31:0] d; int lat, bb, pb;
    sel = 1'b0;
    fetch(24'h000000, 1'b0, 1'b0, 24'h0, d, lat, bb, pb);
    checks++; if (d !== 32'h0B00006F) begin errors++; $display("FAIL div1_data: got %h expected 0b00006f", d); end
    checks++; if (lat !== LAT1) begin errors++; $display("FAIL div1_latency: got %0d expected %0d", lat, LAT1); end
    checks++; if (cap[31:24] !== EXP_CMD) begin errors++; $display("FAIL div1_cmd: got %h expected %h", cap[31:24], EXP_CMD); end
    checks++; if (cap[23:0] !== 24'h000000) begin errors++; $display("FAIL div1_addr: got %h expected 000000", cap[23:0]); end
    checks++; if (io0_nz !== 0) begin errors++; $display("FAIL div1_io0_tail: got %0d high bits expected 0", io0_nz); end
    checks++; if (pb !== 0) begin errors++; $display("FAIL div1_pulse_width: got %0d expected 0", pb); end
    checks++; if (bb !== 0) begin errors++; $display("FAIL div1_ready_busy: got %0d expected 0", bb); end
  endtask

  task automatic test_read_div3;
    logic [31:0] d; int lat, bb, pb, low0;
    sel = 1'b1;
    @(negedge clock);
    low0 = csb_low_cnt;
    fetch(24'h001000, 1'b0, 1'b0, 24'h0, d, lat, bb, pb);
    checks++; if (d !== 32'h0000AB60) begin errors++; $display("FAIL div3_data: got %h expected 0000ab60", d); end
    checks++; if (lat !== LAT3) begin errors++; $display("FAIL div3_latency: got %0d expected %0d", lat, LAT3); end
    checks++; if (rise_cnt !== NB) begin errors++; $display("FAIL div3_sck_rises: got %0d expected %0d", rise_cnt, NB); end
    checks++; if (csb_low_cnt - low0 !== LAT3) begin errors++; $display("FAIL div3_csb_low: got %0d expected %0d", csb_low_cnt - low0, LAT3); end
    checks++; if (m_csb !== 1'b1 || m_clk !== 1'b0) begin errors++; $display("FAIL div3_idle_pads: got csb=%b clk=%b expected 1/0", m_csb, m_clk); end
    checks++; if (cap[23:0] !== 24'h001000) begin errors++; $display("FAIL div3_addr: got %h expected 001000", cap[23:0]); end
    sel = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [31:0] d1, d2; int l1, l2, b1, b2, p1, p2;
    sel = 1'b0;
    fetch(24'h000004, 1'b0, 1'b1, 24'h000008, d1, l1, b1, p1);
    fetch(24'h000008, 1'b0, 1'b0, 24'h0, d2, l2, b2, p2);
    checks++; if (d1 !== 32'h44332211) begin errors++; $display("FAIL b2b_first_data: got %h expected 44332211", d1); end
    checks++; if (d2 !== 32'h3CC35AA5) begin errors++; $display("FAIL b2b_second_data: got %h expected 3cc35aa5", d2); end
    checks++; if (l2 !== LAT1) begin errors++; $display("FAIL b2b_second_latency: got %0d expected %0d", l2, LAT1); end
    checks++; if (last_gap !== 1) begin errors++; $display("FAIL b2b_csb_gap: got %0d expected 1", last_gap); end
    checks++; if (b1 + b2 !== 0) begin errors++; $display("FAIL b2b_ready_busy: got %0d expected 0", b1 + b2); end
  endtask

  task automatic test_unaligned;
    logic [31:0] d; int lat, bb, pb;
    sel = 1'b0;
    fetch(24'h000002, 1'b0, 1'b0, 24'h0, d, lat, bb, pb);
    checks++; if (d !== 32'h22110B00) begin errors++; $display("FAIL unaligned_data: got %h expected 22110b00", d); end
  endtask

  task automatic test_hold_valid;
    logic [31:0] d; int lat, bb, pb;
    sel = 1'b0;
    fetch(24'h001000, 1'b1, 1'b0, 24'h0, d, lat, bb, pb);
    checks++; if (cap[23:0] !== 24'h001000) begin errors++; $display("FAIL hold_addr: got %h expected 001000", cap[23:0]); end
    checks++; if (d !== 32'h0000AB60) begin errors++; $display("FAIL hold_data: got %h expected 0000ab60", d); end
    checks++; if (bb !== 0) begin errors++; $display("FAIL hold_ready_busy: got %0d expected 0", bb); end
    @(negedge clock);
    checks++; if (m_csb !== 1'b1) begin errors++; $display("FAIL hold_no_reaccept: got csb=%b expected 1", m_csb); end
  endtask

  task automatic test_reset_abort;
    logic [31:0] d; int lat, bb, pb, w, seen;
    sel = 1'b0;
    req_addr  = 24'h000008;
    req_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    for (w = 0; w < 500 && rise_cnt < 20; w++) @(negedge clock);
    checks++; if (rise_cnt !== 20) begin errors++; $display("FAIL abort_reach_edge20: got %0d rises expected 20", rise_cnt); end
    reset = 1'b1;
    #1;
    checks++; if (m_csb !== 1'b1) begin errors++; $display("FAIL abort_csb: got %b expected 1", m_csb); end
    checks++; if (m_clk !== 1'b0) begin errors++; $display("FAIL abort_clk: got %b expected 0", m_clk); end
    repeat (2) @(negedge clock);
    reset = 1'b0;
    seen = 0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clock);
      if (m_rvalid === 1'b1) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL abort_no_rvalid: got %0d pulses expected 0", seen); end
    fetch(24'h000004, 1'b0, 1'b0, 24'h0, d, lat, bb, pb);
    checks++; if (d !== 32'h44332211) begin errors++; $display("FAIL abort_next_data: got %h expected 44332211", d); end
    checks++; if (lat !== LAT1) begin errors++; $display("FAIL abort_next_latency: got %0d expected %0d", lat, LAT1); end
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    req_addr  = 24'h0;
    sel       = 1'b0;
    for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
    mem[0]  = 8'h6F; mem[1]  = 8'h00; mem[2]  = 8'h00; mem[3]  = 8'h0B;
    mem[4]  = 8'h11; mem[5]  = 8'h22; mem[6]  = 8'h33; mem[7]  = 8'h44;
    mem[8]  = 8'hA5; mem[9]  = 8'h5A; mem[10] = 8'hC3; mem[11] = 8'h3C;
    mem[4096] = 8'h60; mem[4097] = 8'hAB; mem[4098] = 8'h00; mem[4099] = 8'h00;
    repeat (3) @(negedge clock);
    test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clock);
    test_read_div1();
    test_read_div3();
    test_back_to_back();
    test_unaligned();
    test_hold_valid();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
